// File: rtl/ccu_snoop_responder.sv
// ccu_snoop_responder: cache-side ACE snoop responder; one dcache lookup per AC request,
// answering on CR, streaming the line on CD, and pulsing the resulting line-state update.
module ccu_snoop_responder #(
    parameter int unsigned AddrWidth       = 64,
    parameter int unsigned DcacheLineWidth = 128,
    parameter int unsigned CdDataWidth     = 64
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       ac_valid_i,
    output logic                       ac_ready_o,
    input  logic [AddrWidth-1:0]       ac_addr_i,
    input  logic [3:0]                 ac_snoop_i,
    output logic                       cr_valid_o,
    input  logic                       cr_ready_i,
    output logic [4:0]                 cr_resp_o,
    output logic                       cd_valid_o,
    input  logic                       cd_ready_i,
    output logic [CdDataWidth-1:0]     cd_data_o,
    output logic                       cd_last_o,
    output logic                       cache_req_o,
    input  logic                       cache_gnt_i,
    output logic [AddrWidth-1:0]       cache_addr_o,
    input  logic                       cache_rvalid_i,
    input  logic                       cache_hit_i,
    input  logic                       cache_dirty_i,
    input  logic                       cache_shared_i,
    input  logic [DcacheLineWidth-1:0] cache_line_i,
    output logic                       cache_upd_valid_o,
    output logic                       cache_upd_inval_o,
    output logic                       cache_upd_clr_dirty_o,
    output logic                       cache_upd_set_shared_o,
    output logic                       snoop_unsupported_o
);
    localparam int unsigned Words = DcacheLineWidth / CdDataWidth;
    localparam int unsigned CntW  = (Words > 1) ? $clog2(Words) : 1;
    localparam int unsigned OffW  = $clog2(DcacheLineWidth / 8);
    localparam logic [CntW-1:0] LastBeat = CntW'(Words - 1);
    localparam logic [3:0] READ_ONCE = 4'b0000, READ_SHARED = 4'b0001, READ_UNIQUE = 4'b0111;
    localparam logic [3:0] CLEAN_INVALID = 4'b1001, MAKE_INVALID = 4'b1101;

    typedef enum logic [1:0] {IDLE, LOOKUP, WAIT_RESP, RESP} state_e;

    state_e                   state_q, state_d;
    logic [AddrWidth-1:0]     addr_q, addr_d;
    logic [3:0]               snoop_q, snoop_d;
    logic [4:0]               resp_q, resp_d;
    logic [DcacheLineWidth-1:0] line_q, line_d;
    logic [CntW-1:0]          beat_q, beat_d;
    logic                     cr_done_q, cr_done_d, cd_done_q, cd_done_d;
    logic                     upd_valid_q, upd_valid_d, upd_inval_q, upd_inval_d;
    logic                     upd_clr_q, upd_clr_d, upd_shr_q, upd_shr_d;
    logic                     supported, wu, cr_fin, cd_fin;

    assign supported = ac_snoop_i inside {READ_ONCE, READ_SHARED, READ_UNIQUE, CLEAN_INVALID, MAKE_INVALID};
    assign wu        = cache_hit_i && !cache_shared_i;

    assign ac_ready_o             = state_q == IDLE;
    assign snoop_unsupported_o    = ac_ready_o && ac_valid_i && !supported;
    assign cache_req_o            = state_q == LOOKUP;
    assign cache_addr_o           = {addr_q[AddrWidth-1:OffW], OffW'(0)};
    assign cr_valid_o             = state_q == RESP && !cr_done_q;
    assign cr_resp_o              = resp_q;
    assign cd_valid_o             = state_q == RESP && resp_q[0] && !cd_done_q;
    assign cd_data_o              = line_q[CdDataWidth-1:0];
    assign cd_last_o              = cd_valid_o && beat_q == LastBeat;
    assign cache_upd_valid_o      = upd_valid_q;
    assign cache_upd_inval_o      = upd_inval_q;
    assign cache_upd_clr_dirty_o  = upd_clr_q;
    assign cache_upd_set_shared_o = upd_shr_q;

    assign cr_fin = cr_done_q || (cr_valid_o && cr_ready_i);
    assign cd_fin = !resp_q[0] || cd_done_q || (cd_valid_o && cd_ready_i && cd_last_o);

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        snoop_d     = snoop_q;
        resp_d      = resp_q;
        line_d      = line_q;
        beat_d      = beat_q;
        cr_done_d   = cr_done_q;
        cd_done_d   = cd_done_q;
        upd_inval_d = 1'b0;
        upd_clr_d   = 1'b0;
        upd_shr_d   = 1'b0;
        unique case (state_q)
            IDLE: if (ac_valid_i) begin
                addr_d  = ac_addr_i;
                snoop_d = ac_snoop_i;
                resp_d  = '0;
                state_d = supported ? LOOKUP : RESP;
            end
            LOOKUP: if (cache_gnt_i) state_d = WAIT_RESP;
            WAIT_RESP: if (cache_rvalid_i) begin
                state_d = RESP;
                line_d  = cache_line_i;
                resp_d  = '0;
                if (cache_hit_i) begin
                    case (snoop_q)
                        READ_ONCE:   resp_d = {wu, 1'b1, 1'b0, 1'b0, 1'b1};
                        READ_SHARED: begin
                            resp_d    = {wu, 1'b1, cache_dirty_i, 1'b0, 1'b1};
                            upd_shr_d = 1'b1;
                            upd_clr_d = cache_dirty_i;
                        end
                        READ_UNIQUE: begin
                            resp_d      = {wu, 1'b0, cache_dirty_i, 1'b0, 1'b1};
                            upd_inval_d = 1'b1;
                        end
                        CLEAN_INVALID: begin
                            resp_d      = {wu, 1'b0, cache_dirty_i, 1'b0, cache_dirty_i};
                            upd_inval_d = 1'b1;
                        end
                        default: begin
                            resp_d      = {wu, 4'b0000};
                            upd_inval_d = 1'b1;
                        end
                    endcase
                end
            end
            RESP: begin
                if (cr_valid_o && cr_ready_i) cr_done_d = 1'b1;
                if (cd_valid_o && cd_ready_i) begin
                    beat_d = beat_q + CntW'(1);
                    line_d = line_q >> CdDataWidth;
                    if (cd_last_o) cd_done_d = 1'b1;
                end
                if (cr_fin && cd_fin) begin
                    state_d   = IDLE;
                    cr_done_d = 1'b0;
                    cd_done_d = 1'b0;
                    beat_d    = '0;
                end
            end
            default: state_d = IDLE;
        endcase
        upd_valid_d = upd_inval_d || upd_clr_d || upd_shr_d;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            snoop_q     <= '0;
            resp_q      <= '0;
            line_q      <= '0;
            beat_q      <= '0;
            cr_done_q   <= 1'b0;
            cd_done_q   <= 1'b0;
            upd_valid_q <= 1'b0;
            upd_inval_q <= 1'b0;
            upd_clr_q   <= 1'b0;
            upd_shr_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            snoop_q     <= snoop_d;
            resp_q      <= resp_d;
            line_q      <= line_d;
            beat_q      <= beat_d;
            cr_done_q   <= cr_done_d;
            cd_done_q   <= cd_done_d;
            upd_valid_q <= upd_valid_d;
            upd_inval_q <= upd_inval_d;
            upd_clr_q   <= upd_clr_d;
            upd_shr_q   <= upd_shr_d;
        end
    end
endmodule

// File: tb/tb_ccu_snoop_responder.sv
// tb_ccu_snoop_responder: directed, self-checking bench for the snoop responder.
module tb_ccu_snoop_responder;
    logic         clk_i = 1'b0, rst_ni = 1'b0;
    logic         ac_valid_i = 1'b0, ac_ready_o;
    logic [63:0]  ac_addr_i = '0;
    logic [3:0]   ac_snoop_i = '0;
    logic         cr_valid_o, cr_ready_i = 1'b0;
    logic [4:0]   cr_resp_o;
    logic         cd_valid_o, cd_ready_i = 1'b0, cd_last_o;
    logic [63:0]  cd_data_o;
    logic         cache_req_o, cache_gnt_i = 1'b1;
    logic [63:0]  cache_addr_o;
    logic         cache_rvalid_i = 1'b0, cache_hit_i = 1'b0, cache_dirty_i = 1'b0, cache_shared_i = 1'b0;
    logic [127:0] cache_line_i = '0;
    logic         cache_upd_valid_o, cache_upd_inval_o, cache_upd_clr_dirty_o, cache_upd_set_shared_o;
    logic         snoop_unsupported_o;
    int           passed = 0, total = 0;

    ccu_snoop_responder dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .ac_valid_i(ac_valid_i), .ac_ready_o(ac_ready_o), .ac_addr_i(ac_addr_i), .ac_snoop_i(ac_snoop_i),
        .cr_valid_o(cr_valid_o), .cr_ready_i(cr_ready_i), .cr_resp_o(cr_resp_o),
        .cd_valid_o(cd_valid_o), .cd_ready_i(cd_ready_i), .cd_data_o(cd_data_o), .cd_last_o(cd_last_o),
        .cache_req_o(cache_req_o), .cache_gnt_i(cache_gnt_i), .cache_addr_o(cache_addr_o),
        .cache_rvalid_i(cache_rvalid_i), .cache_hit_i(cache_hit_i), .cache_dirty_i(cache_dirty_i),
        .cache_shared_i(cache_shared_i), .cache_line_i(cache_line_i),
        .cache_upd_valid_o(cache_upd_valid_o), .cache_upd_inval_o(cache_upd_inval_o),
        .cache_upd_clr_dirty_o(cache_upd_clr_dirty_o), .cache_upd_set_shared_o(cache_upd_set_shared_o),
        .snoop_unsupported_o(snoop_unsupported_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Issues an AC request and drives the lookup result; returns in the first RESP cycle.
    task automatic snoop(input logic [63:0] addr, input logic [3:0] op, input logic hit,
                         input logic dirty, input logic shared, input logic [127:0] line);
        ac_valid_i = 1'b1; ac_addr_i = addr; ac_snoop_i = op;
        chk("ac_ready_idle", ac_ready_o, 1'b1);
        tick();
        ac_valid_i = 1'b0;
        chk("cache_req", cache_req_o, 1'b1);
        tick();
        chk("cache_req_drop", cache_req_o, 1'b0);
        cache_rvalid_i = 1'b1; cache_hit_i = hit; cache_dirty_i = dirty; cache_shared_i = shared;
        cache_line_i = line;
        tick();
        cache_rvalid_i = 1'b0; cache_line_i = '0;
    endtask

    initial begin
        tick(); tick();
        chk("rst_ac_ready", ac_ready_o, 1'b1);
        chk("rst_cr_valid", cr_valid_o, 1'b0);
        chk("rst_cd_valid", cd_valid_o, 1'b0);
        chk("rst_cache_req", cache_req_o, 1'b0);
        chk("rst_cd_data", cd_data_o, 64'h0);
        chk("rst_upd_valid", cache_upd_valid_o, 1'b0);
        rst_ni = 1'b1;
        tick();

        ac_valid_i = 1'b1; ac_addr_i = 64'h1000_0048; ac_snoop_i = 4'b0001;
        tick();
        ac_valid_i = 1'b0;
        chk("rs_cache_addr", cache_addr_o, 64'h1000_0040);
        tick();
        cache_rvalid_i = 1'b1; cache_hit_i = 1'b1; cache_dirty_i = 1'b1; cache_shared_i = 1'b0;
        cache_line_i = {64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555};
        tick();
        cache_rvalid_i = 1'b0; cache_line_i = '0;
        chk("rs_cr_valid", cr_valid_o, 1'b1);
        chk("rs_cr_resp", cr_resp_o, 5'b11101);
        chk("rs_cd_valid", cd_valid_o, 1'b1);
        chk("rs_beat0", cd_data_o, 64'h5555_5555_5555_5555);
        chk("rs_last0", cd_last_o, 1'b0);
        chk("rs_upd_valid", cache_upd_valid_o, 1'b1);
        chk("rs_set_shared", cache_upd_set_shared_o, 1'b1);
        chk("rs_clr_dirty", cache_upd_clr_dirty_o, 1'b1);
        chk("rs_inval", cache_upd_inval_o, 1'b0);
        cr_ready_i = 1'b1; cd_ready_i = 1'b1;
        tick();
        chk("rs_beat1", cd_data_o, 64'hAAAA_AAAA_AAAA_AAAA);
        chk("rs_last1", cd_last_o, 1'b1);
        chk("rs_cr_done", cr_valid_o, 1'b0);
        chk("rs_upd_once", cache_upd_valid_o, 1'b0);
        chk("rs_no_ac_ready", ac_ready_o, 1'b0);
        tick();
        chk("rs_idle", ac_ready_o, 1'b1);
        chk("rs_cd_off", cd_valid_o, 1'b0);

        snoop(64'h2000_0000, 4'b0000, 1'b0, 1'b0, 1'b0, 128'h1234);
        chk("ro_miss_cr_valid", cr_valid_o, 1'b1);
        chk("ro_miss_resp", cr_resp_o, 5'b00000);
        chk("ro_miss_cd", cd_valid_o, 1'b0);
        chk("ro_miss_upd", cache_upd_valid_o, 1'b0);
        chk("ro_miss_ac_low", ac_ready_o, 1'b0);
        tick();
        chk("ro_miss_idle", ac_ready_o, 1'b1);
        chk("ro_miss_cd2", cd_valid_o, 1'b0);

        cr_ready_i = 1'b0; cd_ready_i = 1'b0;
        snoop(64'h3000_0010, 4'b0111, 1'b1, 1'b0, 1'b1,
              {64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111});
        chk("ru_resp", cr_resp_o, 5'b00001);
        chk("ru_upd_valid", cache_upd_valid_o, 1'b1);
        chk("ru_inval", cache_upd_inval_o, 1'b1);
        chk("ru_clr", cache_upd_clr_dirty_o, 1'b0);
        chk("ru_beat0", cd_data_o, 64'h1111_1111_1111_1111);
        tick();
        chk("ru_upd_pulse", cache_upd_valid_o, 1'b0);
        chk("ru_stall_data", cd_data_o, 64'h1111_1111_1111_1111);
        chk("ru_stall_valid", cd_valid_o, 1'b1);
        tick();
        chk("ru_stall_data2", cd_data_o, 64'h1111_1111_1111_1111);
        chk("ru_stall_last", cd_last_o, 1'b0);
        tick();
        cd_ready_i = 1'b1;
        chk("ru_stall_data3", cd_data_o, 64'h1111_1111_1111_1111);
        tick();
        chk("ru_beat1", cd_data_o, 64'h2222_2222_2222_2222);
        chk("ru_last1", cd_last_o, 1'b1);
        chk("ru_cr_held", cr_valid_o, 1'b1);
        tick();
        chk("ru_cd_done", cd_valid_o, 1'b0);
        chk("ru_cr_held2", cr_valid_o, 1'b1);
        chk("ru_not_idle", ac_ready_o, 1'b0);
        cr_ready_i = 1'b1;
        tick();
        chk("ru_idle", ac_ready_o, 1'b1);
        chk("ru_cr_off", cr_valid_o, 1'b0);

        snoop(64'h4000_0000, 4'b1001, 1'b1, 1'b0, 1'b0, 128'hFFFF);
        chk("ci_resp", cr_resp_o, 5'b10000);
        chk("ci_cd", cd_valid_o, 1'b0);
        chk("ci_inval", cache_upd_inval_o, 1'b1);
        tick();
        chk("ci_idle", ac_ready_o, 1'b1);

        snoop(64'h5000_0000, 4'b1101, 1'b1, 1'b1, 1'b0, 128'hFFFF);
        chk("mi_resp", cr_resp_o, 5'b10000);
        chk("mi_cd", cd_valid_o, 1'b0);
        chk("mi_inval", cache_upd_inval_o, 1'b1);
        chk("mi_clr", cache_upd_clr_dirty_o, 1'b0);
        tick();
        chk("mi_idle", ac_ready_o, 1'b1);

        ac_valid_i = 1'b1; ac_addr_i = 64'h6000_0000; ac_snoop_i = 4'b1000;
        #1;
        chk("un_pulse", snoop_unsupported_o, 1'b1);
        tick();
        ac_valid_i = 1'b0;
        chk("un_pulse_end", snoop_unsupported_o, 1'b0);
        chk("un_no_req", cache_req_o, 1'b0);
        chk("un_cr_valid", cr_valid_o, 1'b1);
        chk("un_resp", cr_resp_o, 5'b00000);
        chk("un_cd", cd_valid_o, 1'b0);
        chk("un_upd", cache_upd_valid_o, 1'b0);
        tick();
        chk("un_idle", ac_ready_o, 1'b1);

        cr_ready_i = 1'b0; cd_ready_i = 1'b0;
        snoop(64'h7000_0000, 4'b0000, 1'b1, 1'b0, 1'b0,
              {64'hDEAD_DEAD_DEAD_DEAD, 64'hBEEF_BEEF_BEEF_BEEF});
        chk("rst_pre_cd", cd_valid_o, 1'b1);
        rst_ni = 1'b0;
        tick();
        rst_ni = 1'b1;
        chk("rst_mid_cr", cr_valid_o, 1'b0);
        chk("rst_mid_cd", cd_valid_o, 1'b0);
        chk("rst_mid_ac", ac_ready_o, 1'b1);
        chk("rst_mid_upd", cache_upd_valid_o, 1'b0);
        cr_ready_i = 1'b1; cd_ready_i = 1'b1;
        snoop(64'h7000_0000, 4'b0000, 1'b1, 1'b0, 1'b0,
              {64'hBBBB_0000_BBBB_0000, 64'hAAAA_0000_AAAA_0000});
        chk("ro_hit_resp", cr_resp_o, 5'b11001);
        chk("ro_hit_upd", cache_upd_valid_o, 1'b0);
        chk("ro_hit_beat0", cd_data_o, 64'hAAAA_0000_AAAA_0000);
        chk("ro_hit_last0", cd_last_o, 1'b0);
        tick();
        chk("ro_hit_beat1", cd_data_o, 64'hBBBB_0000_BBBB_0000);
        chk("ro_hit_last1", cd_last_o, 1'b1);
        tick();
        chk("ro_hit_idle", ac_ready_o, 1'b1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/ccu_snoop_responder.md
Name: ccu_snoop_responder

Overview:
- Cache-side end of the ACE snoop interface.
- Accepts AC snoop requests from the CCU and performs one lookup in the local dcache.
- Returns the CR snoop response and, when data is transferred, streams the cache line on CD as CdDataWidth beats.
- Issues the resulting line-state update (invalidate / make shared / clean) to the cache. One snoop is in flight at a time.

Parameters:
- AddrWidth, 64, AC/cache address width.
- DcacheLineWidth, 128, cache line width in bits.
- CdDataWidth, 64, CD beat width. DcacheLineWidth must be a multiple of it. DcacheLineWords = DcacheLineWidth/CdDataWidth, must be >= 1.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset, synchronous, active-low.
- ac_valid_i  in  1  snoop request valid.
- ac_ready_o  out  1  snoop request ready.
- ac_addr_i  in  AddrWidth  snoop address.
- ac_snoop_i  in  4  ACE snoop opcode.
- cr_valid_o  out  1  snoop response valid.
- cr_ready_i  in  1  snoop response ready.
- cr_resp_o  out  5  {WasUnique, IsShared, PassDirty, Error, DataTransfer}, bits [4:0].
- cd_valid_o  out  1  snoop data valid.
- cd_ready_i  in  1  snoop data ready.
- cd_data_o  out  CdDataWidth  snoop data beat.
- cd_last_o  out  1  final beat.
- cache_req_o  out  1  lookup request.
- cache_gnt_i  in  1  lookup accepted.
- cache_addr_o  out  AddrWidth  line-aligned lookup address.
- cache_rvalid_i  in  1  lookup result valid, single-cycle pulse.
- cache_hit_i  in  1  line present.
- cache_dirty_i  in  1  line dirty.
- cache_shared_i  in  1  line shared.
- cache_line_i  in  DcacheLineWidth  line data.
- cache_upd_valid_o  out  1  state update, single-cycle pulse, always accepted.
- cache_upd_inval_o  out  1  invalidate line.
- cache_upd_clr_dirty_o  out  1  clear dirty bit.
- cache_upd_set_shared_o  out  1  set shared bit.
- snoop_unsupported_o  out  1  one-cycle pulse on an unsupported opcode.

Behaviour:
- Reset: FSM in IDLE. ac_ready_o=1. All other outputs 0, including data/addr registers, beat counter and flags.
- FSM states IDLE, LOOKUP, WAIT_RESP, RESP.
- IDLE:
  - ac_ready_o=1. On the AC handshake, register opcode and address.
  - Supported opcode -> LOOKUP.
  - Unsupported opcode -> RESP with cr_resp=0 and no lookup; snoop_unsupported_o pulses in the same cycle as the AC handshake.
- Supported opcodes: ReadOnce 0000, ReadShared 0001, ReadUnique 0111, CleanInvalid 1001, MakeInvalid 1101.
- LOOKUP: cache_req_o=1; cache_addr_o = registered address with low log2(DcacheLineWidth/8) bits zeroed. On cache_gnt_i -> WAIT_RESP.
- WAIT_RESP: on cache_rvalid_i, capture hit, dirty, shared and line into registers; compute cr_resp and the update; -> RESP.
- RESP:
  - cr_valid_o=1 until the CR handshake.
  - If DataTransfer=1, cd_valid_o=1 until the last CD handshake. Beats go out in order, bits [CdDataWidth-1:0] first; cd_last_o=1 on beat DcacheLineWords-1.
  - CR and CD are independent and may complete in any order or in the same cycle; done flags track each.
  - cache_upd_valid_o pulses in the first RESP cycle, and only if at least one update bit is set.
  - When both CR and CD (if any) are complete -> IDLE. ac_ready_o rises the next cycle, so there is no AC acceptance in the completing cycle.
- Response table, WU = hit && !shared:
  - Miss: cr_resp=0, no data, no update.
  - ReadOnce hit: DT=1, IS=1, PD=0, WU. No update.
  - ReadShared hit: DT=1, IS=1, PD=dirty, WU. Update set_shared=1, clr_dirty=dirty.
  - ReadUnique hit: DT=1, IS=0, PD=dirty, WU. Update inval=1.
  - CleanInvalid hit: DT=dirty, IS=0, PD=dirty, WU. Update inval=1.
  - MakeInvalid hit: DT=0, PD=0, IS=0, WU. Update inval=1.
  - Error bit is always 0.
- Latency: AC handshake at cycle N -> cache_req_o at N+1. With rvalid at cycle M, cr_valid_o/cd_valid_o/update appear at M+1. Under no backpressure, the last CD beat is at M+DcacheLineWords.
- Line data is captured before the update, so an invalidate never corrupts the CD stream.
- CD stalls (cd_ready_i=0) hold cd_data_o/cd_last_o stable. CR/CD valid never drop before their handshake.
- Synchronous reset mid-operation: return to IDLE next edge, clearing all valids, the beat counter and flags. No update pulse is issued.

Test Plan:
- ReadShared 0x1000_0048, hit dirty not shared, line 0xAAAA..._5555... -> cache_addr_o 0x1000_0040; cr_resp 5'b11101; CD beats 0x5555..., then 0xAAAA... with last; update set_shared=1, clr_dirty=1.
- ReadOnce, miss -> cr_resp 0, cd_valid_o never asserted, no update pulse, ac_ready_o high again one cycle after the CR handshake.
- ReadUnique hit clean shared, cd_ready_i low 3 cycles, cr_ready_i low 5 cycles -> cr_resp 5'b00001; data held stable during stall; inval pulse in the first RESP cycle; IDLE only after both complete.
- CleanInvalid hit clean -> cr_resp 5'b10000, no CD; MakeInvalid hit dirty -> cr_resp 5'b10000, inval=1, no CD.
- ac_snoop_i=1000 -> snoop_unsupported_o pulse, cache_req_o never asserted, cr_resp 0.
- rst_ni low during CD beat 0 -> all valids 0 next cycle, ac_ready_o=1; a fresh ReadOnce hit then returns full data from beat 0.
